// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user (master) and the
// sync_fifo_ctrl pointer/flag controller (slave).
interface sync_fifo_ctrl_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic                rinc;
    logic                clr_err;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE-1:0] raddr;
    logic                wclken;
    logic                wfull;
    logic                rempty;
    logic                walmost_full;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   count;
    logic                overflow;
    logic                underflow;

    modport master (
        output winc, rinc, clr_err,
        input  waddr, raddr, wclken, wfull, rempty,
        input  walmost_full, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, rinc, clr_err,
        output waddr, raddr, wclken, wfull, rempty,
        output walmost_full, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for the fifomem array: owns the binary
// read/write pointers, occupancy count and the full/empty/error flags.
module sync_fifo_ctrl #(
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_ctrl_if.slave  bus
);
    localparam int W = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AFULL_LVL  = W'(AFULL_THRESH);
    localparam logic [ADDRSIZE:0] AEMPTY_LVL = W'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic [ADDRSIZE:0] cnt;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    // Flags come only from registered state, so winc/rinc never reach them
    always_comb begin
        empty   = (wptr == rptr);
        full    = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                  (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
        push_ok = bus.winc & ~full;
        pop_ok  = bus.rinc & ~empty;
    end

    assign bus.waddr         = wptr[ADDRSIZE-1:0];
    assign bus.raddr         = rptr[ADDRSIZE-1:0];
    // Gate with rst so the array can never be written while reset is held
    assign bus.wclken        = push_ok & ~rst;
    assign bus.wfull         = full;
    assign bus.rempty        = empty;
    assign bus.walmost_full  = (cnt >= AFULL_LVL);
    assign bus.ralmost_empty = (cnt <= AEMPTY_LVL);
    assign bus.count         = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + W'(1);
            if (pop_ok)
                rptr <= rptr + W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + W'(1);
                2'b01:   cnt <= cnt - W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags; a fresh error outranks clr_err in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.winc && full)
                bus.overflow <= 1'b1;
            else if (bus.clr_err)
                bus.overflow <= 1'b0;

            if (bus.rinc && empty)
                bus.underflow <= 1'b1;
            else if (bus.clr_err)
                bus.underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl with a behavioural fifomem
// and a queue scoreboard supplying expected data, count and flags.
module tb_sync_fifo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] mem [16];

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0] q[$];
    logic expOvf = 1'b0;
    logic expUnf = 1'b0;

    sync_fifo_ctrl_if #(.ADDRSIZE(4)) bus ();

    sync_fifo_ctrl #(
        .ADDRSIZE(4),
        .AFULL_THRESH(12),
        .AEMPTY_THRESH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural fifomem: registered write, combinational read
    always @(posedge clk) begin
        if (bus.wclken)
            mem[bus.waddr] <= wdata;
    end
    assign rdata = mem[bus.raddr];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic checkState(input string tag);
        int n;
        n = q.size();
        checkOutput({tag, ".count"}, 32'(bus.count), 32'(n));
        checkOutput({tag, ".rempty"}, 32'(bus.rempty), 32'(n == 0));
        checkOutput({tag, ".wfull"}, 32'(bus.wfull), 32'(n == 16));
        checkOutput({tag, ".afull"}, 32'(bus.walmost_full), 32'(n >= 12));
        checkOutput({tag, ".aempty"}, 32'(bus.ralmost_empty), 32'(n <= 2));
        checkOutput({tag, ".ovf"}, 32'(bus.overflow), 32'(expOvf));
        checkOutput({tag, ".unf"}, 32'(bus.underflow), 32'(expUnf));
    endtask

    // One clock of stimulus; called #1 after a rising edge
    task automatic applyStimulus(input string tag, input logic w, input logic r,
                                 input logic c, input logic [7:0] d);
        logic wasFull;
        logic wasEmpty;
        logic expPush;
        logic expPop;
        bus.winc    = w;
        bus.rinc    = r;
        bus.clr_err = c;
        wdata       = d;
        #1;
        wasFull  = (q.size() == 16);
        wasEmpty = (q.size() == 0);
        expPush  = w && !wasFull;
        expPop   = r && !wasEmpty;
        checkOutput({tag, ".wclken"}, 32'(bus.wclken), 32'(expPush));
        if (expPop)
            checkOutput({tag, ".rdata"}, 32'(rdata), 32'(q[0]));
        @(posedge clk);
        if (expPop)
            void'(q.pop_front());
        if (expPush)
            q.push_back(d);
        if (w && wasFull)
            expOvf = 1'b1;
        else if (c)
            expOvf = 1'b0;
        if (r && wasEmpty)
            expUnf = 1'b1;
        else if (c)
            expUnf = 1'b0;
        #1;
        bus.winc    = 1'b0;
        bus.rinc    = 1'b0;
        bus.clr_err = 1'b0;
        checkState(tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.winc    = 1'b0;
        bus.rinc    = 1'b0;
        bus.clr_err = 1'b0;
        #2;
        checkState("por");
        checkOutput("por.wclken", 32'(bus.wclken), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] fill");
        for (int i = 0; i < 16; i++)
            applyStimulus("fill", 1'b1, 1'b0, 1'b0, 8'(i));
        applyStimulus("fill17", 1'b1, 1'b0, 1'b0, 8'hAA);
        applyStimulus("clr1", 1'b0, 1'b0, 1'b1, 8'h00);

        $display("[TB] drain");
        for (int i = 0; i < 16; i++)
            applyStimulus("drain", 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus("drain17", 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus("clr2", 1'b0, 1'b0, 1'b1, 8'h00);

        $display("[TB] wrap");
        for (int i = 0; i < 40; i++)
            applyStimulus("wrap", (i % 4) != 3, (i % 3) != 0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 20 && q.size() > 0; i++)
            applyStimulus("wrapdrain", 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap.emptyAfterDrain", 32'(bus.rempty), 32'(1));

        $display("[TB] simultaneous");
        applyStimulus("sim0", 1'b1, 1'b1, 1'b0, 8'h5A);
        checkOutput("sim0.count", 32'(bus.count), 32'(1));
        checkOutput("sim0.unf", 32'(bus.underflow), 32'(1));
        applyStimulus("clr3", 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 15; i++)
            applyStimulus("refill", 1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        applyStimulus("sim16", 1'b1, 1'b1, 1'b0, 8'hEE);
        checkOutput("sim16.count", 32'(bus.count), 32'(15));
        checkOutput("sim16.ovf", 32'(bus.overflow), 32'(1));
        applyStimulus("clr4", 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++)
            applyStimulus("to5", 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus("sim5", 1'b1, 1'b1, 1'b0, 8'hC5);
        checkOutput("sim5.count", 32'(bus.count), 32'(5));
        checkOutput("sim5.flags", 32'({bus.overflow, bus.underflow}), 32'(0));

        $display("[TB] clr_err priority");
        for (int i = 0; i < 11; i++)
            applyStimulus("to16", 1'b1, 1'b0, 1'b0, 8'(8'hD0 + i));
        applyStimulus("ovfset", 1'b1, 1'b0, 1'b0, 8'hFF);
        applyStimulus("clrvsset", 1'b1, 1'b0, 1'b1, 8'hFF);
        checkOutput("clrvsset.ovf", 32'(bus.overflow), 32'(1));
        applyStimulus("clralone", 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("clralone.flags", 32'({bus.overflow, bus.underflow}), 32'(0));

        $display("[TB] async reset mid-operation");
        applyStimulus("prerst", 1'b0, 1'b1, 1'b0, 8'h00);
        bus.winc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        expOvf = 1'b0;
        expUnf = 1'b0;
        checkState("rst");
        checkOutput("rst.wclken", 32'(bus.wclken), 32'(0));
        checkOutput("rst.raddr", 32'(bus.raddr), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.winc = 1'b0;
        @(posedge clk);
        #1;
        checkState("postrst");
        applyStimulus("postrstpush", 1'b1, 1'b0, 1'b0, 8'h3C);
        applyStimulus("postrstpop", 1'b0, 1'b1, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
